load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-stage load/store engine for the RV32I core; feeds Read_data to the writeback mux.
//  Turns MemRead/MemWrite + funct3 + ALU address into a word-aligned req/ack transaction
//  with byte enables, then aligns and sign/zero-extends load data.
//  Stalls the pipeline until the access completes; a timeout flags dead bus slaves.
// PARAMETERS
//  TIMEOUT_CYCLES  16  WAIT cycles without mem_ack before abort (>=2)
// PORTS
//  clk         in   1   core clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  MemRead     in   1   load in memory stage
//  MemWrite    in   1   store in memory stage (wins if both high)
//  funct3      in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  Address     in   32  byte address from ALU
//  Write_data  in   32  store data (rs2)
//  Read_data   out  32  aligned, extended load result (registered)
//  stall       out  1   hold pipeline while high
//  bus_error   out  1   1-cycle pulse in DONE on timeout
//  misalign    out  1   1-cycle pulse in DONE on misaligned access (0 unless macro)
//  mem_req     out  1   request, held until ack
//  mem_we      out  1   1 = write
//  mem_addr    out  32  {Address[31:2],2'b00}
//  mem_be      out  4   byte enables
//  mem_wdata   out  32  lane-replicated store data
//  mem_rdata   in   32  read word, valid with mem_ack
//  mem_ack     in   1   completes request this cycle
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, including Read_data and the timeout counter.
//  - FSM: IDLE -> WAIT -> DONE -> IDLE.
//    IDLE: on MemRead|MemWrite, register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata;
//          clear counter; -> WAIT.
//    WAIT: hold all mem_* stable. On mem_ack: mem_req=0; if read, capture formatted
//          mem_rdata into Read_data; -> DONE. Counter counts up per WAIT cycle without ack.
//          Count reaching TIMEOUT_CYCLES-1 without ack: mem_req=0, Read_data=0,
//          bus_error=1 in DONE; -> DONE.
//    DONE: one cycle; stall=0 so the pipeline advances; -> IDLE unconditionally.
//  - stall = (IDLE & (MemRead|MemWrite)) | WAIT. stall is combinational; 0 in DONE.
//  - Minimum cost with same-cycle ack: 3 cycles; Read_data valid in the DONE cycle.
//  - Read_data holds its value until the next load completes; stores do not change it.
//  - Load format: B/BU byte lane Address[1:0]; H/HU half lane Address[1].
//    Sign-extend B/H, zero-extend BU/HU. W, and undefined funct3 values, pass the full word.
//  - Store format:
//    SB: be=4'b0001<<A[1:0], wdata={4{b}}.
//    SH: be=A[1]?1100:0011, wdata={2{h}}.
//    SW: be=1111.
//    Loads: be=1111.
//  - Low address bits below natural alignment are ignored (macro off).
//  - Async reset mid-WAIT drops mem_req immediately; the memory must discard the transaction.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H/HU/SH with A[0]=1, or W/SW with A[1:0]!=0, issue no mem_req.
//    IDLE -> DONE directly, with misalign=1 and Read_data=0.
//  MISALIGN_TRAP_EN undefined: misalign tied 0; behaviour as above.
// TESTING
//  1. LB A=0x103, mem_rdata=0x80FF1234, ack 1st WAIT cycle
//     -> mem_addr=0x100, Read_data=0xFFFFFF80, stall high 2 cycles.
//  2. LHU A=0x102, mem_rdata=0x80FF1234 -> Read_data=0x000080FF.
//  3. SH A=0x202, Write_data=0x0000ABCD
//     -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, Read_data unchanged.
//  4. LW, ack withheld -> mem_req drops after TIMEOUT_CYCLES WAIT cycles, bus_error pulse,
//     Read_data=0.
//  5. rst_n low mid-WAIT -> mem_req/stall 0 asynchronously, IDLE after release.
//  6. LW A=0x101: macro on -> no mem_req, misalign pulse;
//     macro off -> mem_addr=0x100, word returned.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory-stage load/store engine for the RV32I core. Converts MemRead /
//   MemWrite + funct3 + ALU address into a single word-aligned req/ack bus
//   transaction with byte enables and lane-replicated store data. Load data is
//   aligned and sign/zero-extended into a registered Read_data. The pipeline is
//   stalled until the access completes. A WAIT-state timeout aborts accesses
//   to dead bus slaves.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned H/HU/SH/W/SW accesses issue no bus request; the
//                 unit goes straight to DONE with a misalign pulse.
//     undefined : misalign is tied 0; low address bits below natural
//                 alignment are ignored.
//
// Ports
//   clk, rst_n            core clock (rising edge), async active-low reset
//   MemRead, MemWrite     access request from the memory stage (write wins)
//   funct3                000 B, 001 H, 010 W, 100 BU, 101 HU
//   Address, Write_data   ALU byte address, store data (rs2)
//   Read_data             aligned/extended load result (registered)
//   stall                 hold pipeline while high (combinational)
//   bus_error, misalign   one-cycle pulses in DONE
//   mem_req/we/addr/be/wdata  bus request, held stable until mem_ack
//   mem_rdata, mem_ack    bus response
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        stall,
  output logic        bus_error,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             bus_error_q, bus_error_d;
  logic             misalign_q, misalign_d;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  store_be = 4'b0001 << a;
      3'b001:  store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  store_wdata = {4{wd[7:0]}};
      3'b001:  store_wdata = {2{wd[15:0]}};
      default: store_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[{a, 3'b000} +: 8];
    h = r[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_format = {{24{b[7]}}, b};
      3'b100:  load_format = {24'd0, b};
      3'b001:  load_format = {{16{h[15]}}, h};
      3'b101:  load_format = {16'd0, h};
      default: load_format = r;  // W and undefined encodings pass the word
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: is_misaligned = a[0];
      3'b010:         is_misaligned = (a != 2'b00);
      default:        is_misaligned = 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    read_data_d = read_data_q;
    bus_error_d = 1'b0;
    misalign_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(funct3, Address[1:0])) begin
            misalign_d  = 1'b1;
            read_data_d = '0;
            state_d     = DONE;
          end else begin
`else
          begin
`endif
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = {Address[31:2], 2'b00};
            mem_be_d    = MemWrite ? store_be(funct3, Address[1:0]) : 4'b1111;
            mem_wdata_d = MemWrite ? store_wdata(funct3, Write_data) : '0;
            funct3_d    = funct3;
            lane_d      = Address[1:0];
            cnt_d       = '0;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over the timeout in the final counted cycle.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) read_data_d = load_format(funct3_q, lane_q, mem_rdata);
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d   = 1'b0;
          read_data_d = '0;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      funct3_q    <= '0;
      lane_q      <= '0;
      read_data_q <= '0;
      bus_error_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      read_data_q <= read_data_d;
      bus_error_q <= bus_error_d;
      misalign_q  <= misalign_d;
    end
  end

  // Gated by rst_n so stall drops the moment reset asserts, even if the
  // pipeline is still presenting the access.
  assign stall = rst_n & (((state_q == IDLE) & (MemRead | MemWrite)) | (state_q == WAIT));

  assign Read_data = read_data_q;
  assign bus_error = bus_error_q;
  assign misalign  = misalign_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] Address = '0, Write_data = '0;
  logic [31:0] Read_data;
  logic        stall, bus_error, misalign;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .Address(Address), .Write_data(Write_data),
    .Read_data(Read_data), .stall(stall), .bus_error(bus_error), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] addr, wdata, rd;
    bit [3:0]  be;
    bit        we, berr, mis, req;
    int        req_cycles;
  } exp_t;

  typedef struct {
    bit [31:0] rdata;
    int        delay;
    bit        timeout;
  } resp_t;

  exp_t  sb_q[$];
  resp_t resp_q[$];
  int    n_cmp = 0, n_fail = 0;
  bit [31:0] exp_rd = 0;   // model of Read_data
  bit    done_all = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: describes the bus request and the result purely from
  // the architectural load/store rules.
  function automatic exp_t model(input bit rd, input bit wr, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [31:0] wd,
                                 input bit [31:0] r, input bit tmo, input int dly,
                                 input bit [31:0] prev);
    exp_t e;
    int   sh;
    bit [31:0] v;
    e.we = wr;
    e.addr = a & 32'hFFFF_FFFC;
    e.be = 4'hF;
    e.wdata = 0;
    e.berr = 0;
    e.mis = 0;
`ifdef MISALIGN_TRAP_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) e.mis = 1;
    if (f3 == 3'b010 && a[1:0] != 0) e.mis = 1;
`endif
    e.req = !e.mis;
    e.req_cycles = tmo ? T : dly + 1;
    if (wr) begin
      if (f3 == 3'b000) begin
        e.be = 4'(1 << a[1:0]);
        e.wdata = (wd & 32'hFF) * 32'h0101_0101;
      end else if (f3 == 3'b001) begin
        e.be = 4'(3 << (2 * a[1]));
        e.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      end else begin
        e.wdata = wd;
      end
    end
    if (e.mis) e.rd = 0;
    else if (tmo) begin e.rd = 0; e.berr = 1; end
    else if (!wr) begin
      case (f3)
        3'b000, 3'b100: begin
          sh = 8 * int'(a[1:0]);
          v = (r >> sh) & 32'hFF;
          if (f3 == 3'b000 && v >= 128) v = v - 256;
          e.rd = v;
        end
        3'b001, 3'b101: begin
          sh = 16 * int'(a[1]);
          v = (r >> sh) & 32'hFFFF;
          if (f3 == 3'b001 && v >= 32768) v = v - 65536;
          e.rd = v;
        end
        default: e.rd = r;
      endcase
    end else e.rd = prev;
    return e;
  endfunction

  task automatic issue(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit [31:0] r, input int dly, input bit tmo);
    exp_t  e;
    resp_t rs;
    bit    ok;
    e = model(rd, wr, f3, a, wd, r, tmo, dly, exp_rd);
    exp_rd = e.rd;
    if (e.req) begin
      rs.rdata = r; rs.delay = dly; rs.timeout = tmo;
      resp_q.push_back(rs);
    end
    @(posedge clk); #1;
    sb_q.push_back(e);
    MemRead = rd; MemWrite = wr; funct3 = f3; Address = a; Write_data = wd;
    ok = 0;
    for (int i = 0; i < 4 * T; i++) begin
      @(negedge clk);
      if (!stall) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", 4 * T);
    end
    MemRead = 0; MemWrite = 0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // Bus slave: acks after the scheduled delay, or never for timeout cases.
  initial begin
    resp_t rs;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mem_req && resp_q.size() > 0) begin
        rs = resp_q.pop_front();
        if (rs.timeout) begin
          while (mem_req) begin @(posedge clk); #1; end
        end else begin
          repeat (rs.delay) begin @(posedge clk); #1; end
          mem_rdata = rs.rdata; mem_ack = 1;
          @(posedge clk); #1;
          mem_ack = 0; mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: checks the request when it first appears and the result in DONE.
  initial begin
    exp_t e;
    int   req_cnt = 0, stall_cnt = 0;
    bit   prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete(); req_cnt = 0; stall_cnt = 0; prev_stall = 0;
        continue;
      end
      if (mem_req) begin
        if (req_cnt == 0) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_req: got mem_req=1 expected no request");
          end else begin
            e = sb_q[0];
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_be", {28'd0, mem_be}, {28'd0, e.be});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          end
        end
        req_cnt++;
      end
      if (stall) stall_cnt++;
      if (prev_stall && !stall) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = sb_q.pop_front();
          chk("Read_data", Read_data, e.rd);
          chk("bus_error", {31'd0, bus_error}, {31'd0, e.berr});
          chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
          chk("req_cycles", req_cnt, e.req ? e.req_cycles : 0);
          chk("stall_cycles", stall_cnt, e.req ? e.req_cycles + 1 : 1);
          chk("req_in_done", {31'd0, mem_req}, 32'd0);
        end
        req_cnt = 0; stall_cnt = 0;
      end
      prev_stall = stall;
    end
  end

  initial begin
    bit rd, wr;
    bit [2:0] f3;
    int dly;
    bit tmo;
    bit [2:0] ld_f3[8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_Read_data", Read_data, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", {28'd0, mem_be}, 0);
    chk("rst_bus_error", {31'd0, bus_error}, 0);
    @(negedge clk); rst_n = 1;

    // Directed cases
    issue(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 0, 0);          // LB
    issue(1, 0, 3'b101, 32'h102, 0, 32'h80FF1234, 1, 0);          // LHU
    issue(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h12345678, 2, 0); // SH
    issue(1, 0, 3'b010, 32'h300, 0, 32'hDEADBEEF, 0, 1);          // LW timeout
    issue(1, 0, 3'b010, 32'h101, 0, 32'hCAFEF00D, T - 1, 0);      // LW odd addr, late ack
    issue(1, 1, 3'b000, 32'h401, 32'h000000A5, 32'h11111111, 0, 0); // both high: store

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      wr = $urandom_range(0, 1);
      rd = wr ? $urandom_range(0, 1) : 1'b1;
      f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 7)];
      tmo = ($urandom_range(0, 15) == 0);
      dly = ($urandom_range(0, 9) == 0) ? T - 1 : $urandom_range(0, 3);
      issue(rd, wr, f3, $urandom, $urandom, $urandom, dly, tmo);
    end

    // Async reset in the middle of WAIT
    begin
      exp_t  e;
      resp_t rs;
      rs.rdata = 0; rs.delay = 0; rs.timeout = 1;
      resp_q.push_back(rs);
      e = model(1, 0, 3'b010, 32'h500, 0, 0, 1, 0, exp_rd);
      @(posedge clk); #1;
      sb_q.push_back(e);
      MemRead = 1; funct3 = 3'b010; Address = 32'h500;
      repeat (3) @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_mem_req", {31'd0, mem_req}, 0);
      chk("arst_stall", {31'd0, stall}, 0);
      chk("arst_Read_data", Read_data, 0);
      exp_rd = 0;
      MemRead = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_stall", {31'd0, stall}, 0);
      chk("post_rst_mem_req", {31'd0, mem_req}, 0);
      resp_q.delete();
    end
    issue(1, 0, 3'b100, 32'h601, 0, 32'h00C30000, 0, 0);          // LBU after reset

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
